// File: rtl/rls_pkg.sv
// ---------------------------------------------------------------------------
// rls_pkg
// Shared definitions for the RLS datapath: the Q16.16 fixed-point format used
// by every stage (width, fractional bits, the value 1.0 and the saturation
// limits) and the state encoding of the inner-product engine.
// No ports; import with "import rls_pkg::*;".
// ---------------------------------------------------------------------------
package rls_pkg;

  // Q format shared by the regressor, the weights and the inner-product result
  localparam int              Q_W    = 32;
  localparam int              Q_FRAC = 16;
  localparam logic [Q_W-1:0]  Q_ONE  = 32'h0001_0000;
  localparam logic [Q_W-1:0]  Q_MAX  = 32'h7FFF_FFFF;
  localparam logic [Q_W-1:0]  Q_MIN  = 32'h8000_0000;

  // Inner-product engine states: waiting for start, taking element pairs,
  // and the single cycle in which the wide sum is saturated into the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } mac_state_t;

endpackage

// File: rtl/q_mul.sv
// ---------------------------------------------------------------------------
// q_mul
// Combinational signed fixed-point multiply: the full 2W-bit product of two
// signed Q operands, arithmetically shifted right by FRAC (rounding toward
// minus infinity). The result keeps all 2W-FRAC significant bits so callers
// can accumulate without losing range. Reused by the gain/update stages.
// Ports:
//   a, b : W-bit signed Q operands
//   p    : (2W-FRAC)-bit signed product, same number of fractional bits as a/b
// ---------------------------------------------------------------------------
module q_mul
  import rls_pkg::*;
#(
  parameter int W    = Q_W,
  parameter int FRAC = Q_FRAC
) (
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  output logic [2*W-FRAC-1:0] p
);

  localparam int PW = 2 * W - FRAC;

  logic signed [2*W-1:0] a_ext;
  logic signed [2*W-1:0] b_ext;
  logic signed [2*W-1:0] full;

  // Operands are sign-extended to the product width before multiplying so the
  // multiply is a true signed W x W product. Dropping the low FRAC bits of an
  // arithmetic shift keeps the Q alignment; the top bits of the shifted value
  // are only sign copies and are discarded by the cast.
  always_comb begin
    a_ext = (2*W)'($signed(a));
    b_ext = (2*W)'($signed(b));
    full  = a_ext * b_ext;
    p     = PW'(full >>> FRAC);
  end

endmodule

// File: rtl/rls_inner_product_mac.sv
// ---------------------------------------------------------------------------
// rls_inner_product_mac
// Serial fixed-point inner product s = sum a_i*b_i over N element pairs,
// one pair per accepted beat, fed by the regressor shift register and the
// weight store. Products are summed in a wide accumulator and saturated to
// W bits once, after the last pair.
// Ports:
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   start           : pulse to begin a product (only honoured when idle)
//   abort           : drop the current product, no result is produced
//   a_in, b_in      : element pair (signed Q), qualified by in_valid
//   in_valid        : pair valid this cycle
//   in_ready        : engine takes a pair this cycle (accumulating only)
//   s, ovf          : saturated result and its saturation flag, held
//   s_valid         : one-cycle pulse when s/ovf are updated
//   busy            : a product is in progress
// ---------------------------------------------------------------------------
module rls_inner_product_mac
  import rls_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = Q_W,
  parameter int FRAC  = Q_FRAC,
  parameter int ACC_W = 48
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] s,
  output logic         s_valid,
  output logic         ovf,
  output logic         busy
);

  localparam int PW    = 2 * W - FRAC;
  localparam int EXT_W = (ACC_W > PW) ? ACC_W : PW;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [W-1:0]     S_MAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]     S_MIN    = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  mac_state_t state;
  mac_state_t state_next;

  logic signed [ACC_W-1:0] acc;
  logic        [CNT_W-1:0] cnt;
  logic        [PW-1:0]    prod;
  logic signed [EXT_W-1:0] prod_ext;
  logic signed [EXT_W-1:0] acc_ext;
  logic signed [EXT_W-1:0] sum_ext;
  logic                    beat;
  logic                    last_beat;
  logic                    fits;
  logic                    sat_hi;
  logic                    sat_lo;

  q_mul #(
    .W    (W),
    .FRAC (FRAC)
  ) u_q_mul (
    .a (a_in),
    .b (b_in),
    .p (prod)
  );

  // Ready depends on state alone so the upstream stores never see a
  // combinational path from their own valid back to ready.
  assign in_ready = (state == ACC);

  // A beat is only taken when no abort is pending: abort discards the pair
  // offered in the same cycle.
  assign beat      = in_ready && in_valid && !abort;
  assign last_beat = beat && (cnt == CNT_LAST);

  // Product and accumulator are brought to a common signed width before the
  // add, so the shifted product is sign-extended into the running sum.
  always_comb begin
    prod_ext = EXT_W'($signed(prod));
    acc_ext  = EXT_W'(acc);
    sum_ext  = acc_ext + prod_ext;
  end

  // The sum fits in W bits exactly when every accumulator bit from W-1 up is
  // a copy of the sign; otherwise the sign picks the saturation direction.
  always_comb begin
    fits   = (&acc[ACC_W-1:W-1]) || !(|acc[ACC_W-1:W-1]);
    sat_hi = !fits && !acc[ACC_W-1];
    sat_lo = !fits &&  acc[ACC_W-1];
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Abort beats everything; start is only looked at when
  // idle, so a start during a product never restarts it. DONE always lasts a
  // single cycle, which is the cycle the result register is loaded.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start)     state_next = ACC;
        ACC:     if (last_beat) state_next = DONE;
        DONE:                   state_next = IDLE;
        default:                state_next = IDLE;
      endcase
    end
  end

  // Datapath: clear the sum on start, accumulate on beats, and on the DONE
  // cycle saturate into s/ovf with a one-cycle s_valid. An abort only drops
  // busy; s and ovf keep the last real result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      cnt     <= '0;
      s       <= '0;
      s_valid <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      s_valid <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              acc  <= '0;
              cnt  <= '0;
              busy <= 1'b1;
            end
          end
          ACC: begin
            if (beat) begin
              acc <= ACC_W'(sum_ext);
              cnt <= cnt + CNT_W'(1);
            end
          end
          DONE: begin
            if (sat_hi) begin
              s   <= S_MAX;
              ovf <= 1'b1;
            end else if (sat_lo) begin
              s   <= S_MIN;
              ovf <= 1'b1;
            end else begin
              s   <= acc[W-1:0];
              ovf <= 1'b0;
            end
            s_valid <= 1'b1;
            busy    <= 1'b0;
          end
          default: begin
            busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rls_inner_product_mac.sv
// ---------------------------------------------------------------------------
// tb_rls_inner_product_mac
// Directed, table-driven bench for the serial inner-product engine. A second
// instance with N=1 covers the single-beat product.
// ---------------------------------------------------------------------------
module tb_rls_inner_product_mac;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int FRAC  = 16;
  // Wide enough that four full-scale products cannot wrap before saturation
  localparam int ACC_W = 64;
  localparam int NV    = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         abort;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] s;
  logic         s_valid;
  logic         ovf;
  logic         busy;

  logic         start1;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         in_valid1;
  logic         in_ready1;
  logic [W-1:0] s1;
  logic         s_valid1;
  logic         ovf1;
  logic         busy1;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    string                 name;
    logic [N-1:0][W-1:0]   a;
    logic [N-1:0][W-1:0]   b;
    logic [W-1:0]          exp_s;
    logic                  exp_ovf;
  } vec_t;

  vec_t vecs [NV];

  rls_inner_product_mac #(
    .N(N), .W(W), .FRAC(FRAC), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .s_valid(s_valid), .ovf(ovf), .busy(busy)
  );

  rls_inner_product_mac #(
    .N(1), .W(W), .FRAC(FRAC), .ACC_W(48)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort),
    .a_in(a1), .b_in(b1), .in_valid(in_valid1), .in_ready(in_ready1),
    .s(s1), .s_valid(s_valid1), .ovf(ovf1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input string n,
                              input logic [W-1:0] a0, input logic [W-1:0] a1v,
                              input logic [W-1:0] a2, input logic [W-1:0] a3,
                              input logic [W-1:0] b0, input logic [W-1:0] b1v,
                              input logic [W-1:0] b2, input logic [W-1:0] b3,
                              input logic [W-1:0] es, input logic eo);
    vec_t v;
    v.name    = n;
    v.a[0]    = a0;  v.a[1] = a1v; v.a[2] = a2; v.a[3] = a3;
    v.b[0]    = b0;  v.b[1] = b1v; v.b[2] = b2; v.b[3] = b3;
    v.exp_s   = es;
    v.exp_ovf = eo;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks_total++;
    if (act === exp) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Runs one product on the N=4 engine. pat gives in_valid per offered cycle
  // (LSB first, all ones past bit 15); poke_start raises start alongside the
  // second offered pair; tail checks the cycle after the s_valid pulse.
  task automatic applyStimulus(input vec_t v, input logic [15:0] pat,
                               input bit poke_start, input bit tail);
    int idx;
    int k;
    int edges;
    int waited;
    idx   = 0;
    k     = 0;
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    checkOutput($sformatf("%s/busy_acc", v.name), W'(busy), W'(1));
    while (idx < N && k < 32) begin
      checkOutput($sformatf("%s/in_ready_%0d", v.name, k), W'(in_ready), W'(1));
      in_valid = (k < 16) ? pat[k] : 1'b1;
      start    = poke_start && (k == 1);
      if (in_valid) begin
        a_in = v.a[idx];
        b_in = v.b[idx];
      end else begin
        a_in = $urandom;
        b_in = $urandom;
      end
      @(posedge clk); #1;
      edges++;
      if (in_valid) idx++;
      k++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    checkOutput($sformatf("%s/beats", v.name), W'(idx), W'(N));
    checkOutput($sformatf("%s/in_ready_done", v.name), W'(in_ready), W'(0));
    checkOutput($sformatf("%s/s_valid_early", v.name), W'(s_valid), W'(0));
    waited = 0;
    while (!s_valid && waited < 8) begin
      @(posedge clk); #1;
      edges++;
      waited++;
    end
    checkOutput($sformatf("%s/s_valid", v.name), W'(s_valid), W'(1));
    checkOutput($sformatf("%s/s", v.name), s, v.exp_s);
    checkOutput($sformatf("%s/ovf", v.name), W'(ovf), W'(v.exp_ovf));
    checkOutput($sformatf("%s/busy_end", v.name), W'(busy), W'(0));
    checkOutput($sformatf("%s/latency", v.name), W'(edges), W'(k + 2));
    if (tail) begin
      @(posedge clk); #1;
      checkOutput($sformatf("%s/s_valid_pulse", v.name), W'(s_valid), W'(0));
      checkOutput($sformatf("%s/s_hold", v.name), s, v.exp_s);
    end
  endtask

  initial begin
    int seen;

    // Q16.16: 1.0=0001_0000 2.0=0002_0000 -0.5=FFFF_8000 3.0=0003_0000 0.5=0000_8000
    vecs[0] = mk("unit_mix", 32'h0001_0000, 32'h0002_0000, 32'hFFFF_8000, 32'h0003_0000,
                 32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'h0003_8000, 1'b0);
    vecs[1] = mk("sat_pos", 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000,
                 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_FFFF, 1'b1);
    vecs[2] = mk("sat_neg", 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000,
                 32'h8001_0000, 32'h8001_0000, 32'h8001_0000, 32'h8001_0000, 32'h8000_0000, 1'b1);
    vecs[3] = mk("neg_sum", 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFFC_0000, 1'b0);
    // -1 LSB * 0.5 floors to -1 LSB per term
    vecs[4] = mk("trunc_floor", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'hFFFF_FFFC, 1'b0);
    vecs[5] = mk("at_max", 32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0,
                 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h7FFF_FFFF, 1'b0);
    vecs[6] = mk("over_max", 32'h7FFF_FFFF, 32'h0000_0001, 32'h0, 32'h0,
                 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h7FFF_FFFF, 1'b1);
    vecs[7] = mk("at_min", 32'h8000_0000, 32'h0, 32'h0, 32'h0,
                 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h8000_0000, 1'b0);
    vecs[8] = mk("under_min", 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0,
                 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h8000_0000, 1'b1);
    // 1.5*2 + (-2)*0.5 + 0.25*4 + 1*(-1) = 2.0
    vecs[9] = mk("frac_mix", 32'h0001_8000, 32'hFFFE_0000, 32'h0000_4000, 32'h0001_0000,
                 32'h0002_0000, 32'h0000_8000, 32'h0004_0000, 32'hFFFF_0000, 32'h0002_0000, 1'b0);

    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
    start1 = 1'b0; in_valid1 = 1'b0; a1 = '0; b1 = '0;
    #1;
    checkOutput("reset/s", s, 32'h0);
    checkOutput("reset/s_valid", W'(s_valid), W'(0));
    checkOutput("reset/ovf", W'(ovf), W'(0));
    checkOutput("reset/busy", W'(busy), W'(0));
    checkOutput("reset/in_ready", W'(in_ready), W'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Single-beat engine: 2.0 * 1.5 = 3.0
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    checkOutput("n1/in_ready", W'(in_ready1), W'(1));
    in_valid1 = 1'b1; a1 = 32'h0002_0000; b1 = 32'h0001_8000;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    checkOutput("n1/in_ready_done", W'(in_ready1), W'(0));
    checkOutput("n1/s_valid_early", W'(s_valid1), W'(0));
    @(posedge clk); #1;
    checkOutput("n1/s_valid", W'(s_valid1), W'(1));
    checkOutput("n1/s", s1, 32'h0003_0000);
    checkOutput("n1/ovf", W'(ovf1), W'(0));

    // Table of full products with in_valid held high
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i], 16'hFFFF, 1'b0, 1'b1);
    end

    // Gapped valid pattern 1,0,0,1,0,1,1
    applyStimulus(vecs[0], 16'h0069, 1'b0, 1'b1);

    // Start during accumulation is ignored
    applyStimulus(vecs[9], 16'hFFFF, 1'b1, 1'b1);

    // Back-to-back: start in the s_valid cycle
    applyStimulus(vecs[9], 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(vecs[3], 16'hFFFF, 1'b0, 1'b1);

    // Abort after two beats keeps the previous saturated result
    applyStimulus(vecs[2], 16'hFFFF, 1'b0, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_in = vecs[0].a[i];
      b_in = vecs[0].b[i];
      @(posedge clk); #1;
    end
    abort = 1'b1;
    a_in = vecs[0].a[2];
    b_in = vecs[0].b[2];
    @(posedge clk); #1;
    abort = 1'b0;
    in_valid = 1'b0;
    checkOutput("abort/busy", W'(busy), W'(0));
    checkOutput("abort/in_ready", W'(in_ready), W'(0));
    checkOutput("abort/s_keep", s, 32'h8000_0000);
    checkOutput("abort/ovf_keep", W'(ovf), W'(1));
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (s_valid) seen++;
      @(posedge clk); #1;
    end
    checkOutput("abort/no_s_valid", W'(seen), W'(0));
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    checkOutput("abort_start/busy", W'(busy), W'(0));
    checkOutput("abort_start/in_ready", W'(in_ready), W'(0));
    applyStimulus(vecs[0], 16'hFFFF, 1'b0, 1'b1);

    // Asynchronous reset in the middle of accumulation
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_in = vecs[0].a[i];
      b_in = vecs[0].b[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset/s", s, 32'h0);
    checkOutput("async_reset/busy", W'(busy), W'(0));
    checkOutput("async_reset/in_ready", W'(in_ready), W'(0));
    checkOutput("async_reset/ovf", W'(ovf), W'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (s_valid) seen++;
    end
    checkOutput("async_reset/no_s_valid", W'(seen), W'(0));
    checkOutput("async_reset/idle_busy", W'(busy), W'(0));

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
